// File: rtl/cpu_host_loader.sv
// Host-side initiator for the CPU external memory ports: turns a valid/ready
// command stream into single-cycle SRAM strobes and bounded CPU enable windows.
module cpu_host_loader #(
  parameter int CNT_W  = 32,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [63:0] cmd_addr,
  input  logic [63:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [2:0] OP_WR_I = 3'd0;
  localparam logic [2:0] OP_WR_D = 3'd1;
  localparam logic [2:0] OP_RD_I = 3'd2;
  localparam logic [2:0] OP_RD_D = 3'd3;
  localparam logic [2:0] OP_RUN  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RUN      = 3'd4,
    ST_RESP     = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [63:0]        addr_q, addr_d;
  logic [63:0]        data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [63:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;
  logic               enable_q, enable_d;
  logic [63:0]        addr_ext_q, addr_ext_d;
  logic               wen_ext_q, wen_ext_d;
  logic               ren_ext_q, ren_ext_d;
  logic [31:0]        wdata_ext_q, wdata_ext_d;
  logic [63:0]        addr_ext_2_q, addr_ext_2_d;
  logic               wen_ext_2_q, wen_ext_2_d;
  logic               ren_ext_2_q, ren_ext_2_d;
  logic [63:0]        wdata_ext_2_q, wdata_ext_2_d;

  // Handshakes: a command transfers on a cycle where cmd_valid & cmd_ready are
  // both high, a response on rsp_valid & rsp_ready; the offering side keeps its
  // payload stable until that cycle and the other side never consumes earlier.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d       = cmd_op;
          addr_d     = cmd_addr;
          data_d     = cmd_data;
          cnt_d      = cmd_data[CNT_W-1:0];
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          case (cmd_op)
            OP_WR_I, OP_WR_D: state_d = ST_WRITE;
            OP_RD_I, OP_RD_D: state_d = ST_RD_ISSUE;
            OP_RUN: begin
              if (cmd_data[CNT_W-1:0] == '0) state_d = ST_RESP;
              else                           state_d = ST_RUN;
            end
            default: begin
              state_d   = ST_RESP;
              rsp_err_d = 1'b1;
            end
          endcase
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RD_ISSUE: begin
        state_d = ST_RD_WAIT;
        lat_d   = LAT_W'(RD_LAT - 1);
      end
      ST_RD_WAIT: begin
        // The final wait cycle is the one in which the SRAM presents the word.
        if (lat_q == '0) begin
          state_d = ST_RESP;
          if (op_q == OP_RD_I) rsp_data_d = {32'd0, rdata_ext};
          else                 rsp_data_d = rdata_ext_2;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one lines up with the
  // cycle its state occupies.
  always_comb begin
    cmd_ready_d   = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
    rsp_valid_d   = (state_d == ST_RESP);
    enable_d      = (state_d == ST_RUN);
    wen_ext_d     = (state_d == ST_WRITE)    && (op_d == OP_WR_I);
    wen_ext_2_d   = (state_d == ST_WRITE)    && (op_d == OP_WR_D);
    ren_ext_d     = (state_d == ST_RD_ISSUE) && (op_d == OP_RD_I);
    ren_ext_2_d   = (state_d == ST_RD_ISSUE) && (op_d == OP_RD_D);
    addr_ext_d    = (wen_ext_d || ren_ext_d)     ? addr_d       : '0;
    addr_ext_2_d  = (wen_ext_2_d || ren_ext_2_d) ? addr_d       : '0;
    wdata_ext_d   = wen_ext_d                    ? data_d[31:0] : '0;
    wdata_ext_2_d = wen_ext_2_d                  ? data_d       : '0;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      cnt_q         <= '0;
      lat_q         <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      enable_q      <= 1'b0;
      addr_ext_q    <= '0;
      wen_ext_q     <= 1'b0;
      ren_ext_q     <= 1'b0;
      wdata_ext_q   <= '0;
      addr_ext_2_q  <= '0;
      wen_ext_2_q   <= 1'b0;
      ren_ext_2_q   <= 1'b0;
      wdata_ext_2_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      lat_q         <= lat_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      busy_q        <= busy_d;
      enable_q      <= enable_d;
      addr_ext_q    <= addr_ext_d;
      wen_ext_q     <= wen_ext_d;
      ren_ext_q     <= ren_ext_d;
      wdata_ext_q   <= wdata_ext_d;
      addr_ext_2_q  <= addr_ext_2_d;
      wen_ext_2_q   <= wen_ext_2_d;
      ren_ext_2_q   <= ren_ext_2_d;
      wdata_ext_2_q <= wdata_ext_2_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign enable      = enable_q;
  assign addr_ext    = addr_ext_q;
  assign wen_ext     = wen_ext_q;
  assign ren_ext     = ren_ext_q;
  assign wdata_ext   = wdata_ext_q;
  assign addr_ext_2  = addr_ext_2_q;
  assign wen_ext_2   = wen_ext_2_q;
  assign ren_ext_2   = ren_ext_2_q;
  assign wdata_ext_2 = wdata_ext_2_q;

endmodule
